spi_encoder: RTL and testbench



---
 rtl/spi_encoder.sv | 139 +++++++++++++
 tb/tb_spi_encoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_encoder.sv
// SPI mode-0 master transmitter: serialises bytes MSB first onto sclk/mosi/csn,
// grouping consecutive bytes into one chip-select frame until a byte flagged last.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | csn high, waiting for the first byte of a frame
// SETUP | csn low, sclk low, first bit of a byte presented on mosi
// HIGH  | sclk high half-period (slave samples mosi on the rise)
// LOW   | sclk low half-period, next bit presented on mosi
// NEXT  | byte finished mid-frame, csn held low, waiting for the next byte
// HOLD  | sclk low half-period after the final rise of the frame
// GAP   | csn high, enforcing the minimum inter-frame gap
module spi_encoder #(
  parameter int HALF_PERIOD = 2,
  parameter int CS_GAP      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       abort,
  output logic       sclk,
  output logic       mosi,
  output logic       csn,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, NEXT, HOLD, GAP} state_t;

  // The IDLE cycle in which the next byte is accepted is the last cycle of the
  // csn-high window, so GAP itself only covers CS_GAP-1 cycles and is skipped
  // altogether when CS_GAP is 1.
  localparam logic [7:0] HP_LOAD   = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] GAP_LOAD  = 8'((CS_GAP > 1) ? (CS_GAP - 2) : 0);
  localparam state_t     GAP_ENTRY = (CS_GAP > 1) ? GAP : IDLE;

  state_t     state;
  logic [7:0] shift;
  logic [7:0] half_cnt;
  logic [7:0] gap_cnt;
  logic [3:0] bit_cnt;
  logic       last_q;
  logic       accept;
  logic       abort_hit;

  assign tx_ready  = (state == IDLE) || ((state == NEXT) && !abort);
  assign busy      = (state != IDLE);
  assign accept    = tx_valid && tx_ready;
  assign abort_hit = abort && (state != IDLE) && (state != GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= 8'd0;
      half_cnt <= 8'd0;
      gap_cnt  <= 8'd0;
      bit_cnt  <= 4'd0;
      last_q   <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      csn      <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        csn     <= 1'b1;
        sclk    <= 1'b0;
        mosi    <= 1'b0;
        shift   <= 8'd0;
        bit_cnt <= 4'd0;
        last_q  <= 1'b0;
        gap_cnt <= GAP_LOAD;
        state   <= GAP_ENTRY;
      end else begin
        case (state)
          IDLE, NEXT: begin
            if (accept) begin
              csn      <= 1'b0;
              mosi     <= tx_data[7];
              shift    <= {tx_data[6:0], 1'b0};
              last_q   <= tx_last;
              bit_cnt  <= 4'd0;
              half_cnt <= HP_LOAD;
              state    <= SETUP;
            end
          end
          SETUP, LOW: begin
            if (half_cnt == 8'd0) begin
              sclk     <= 1'b1;
              half_cnt <= HP_LOAD;
              state    <= HIGH;
            end else begin
              half_cnt <= half_cnt - 8'd1;
            end
          end
          HIGH: begin
            if (half_cnt == 8'd0) begin
              sclk     <= 1'b0;
              half_cnt <= HP_LOAD;
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state <= last_q ? HOLD : NEXT;
              end else begin
                mosi  <= shift[7];
                shift <= {shift[6:0], 1'b0};
                state <= LOW;
              end
            end else begin
              half_cnt <= half_cnt - 8'd1;
            end
          end
          HOLD: begin
            if (half_cnt == 8'd0) begin
              csn     <= 1'b1;
              done    <= 1'b1;
              mosi    <= 1'b0;
              gap_cnt <= GAP_LOAD;
              state   <= GAP_ENTRY;
            end else begin
              half_cnt <= half_cnt - 8'd1;
            end
          end
          GAP: begin
            if (gap_cnt == 8'd0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt - 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_encoder.sv
// Bench for spi_encoder: a behavioural SPI decoder feeds a scoreboard of expected bytes,
// plus frame-timing measurements on a default instance and a HALF_PERIOD=1/CS_GAP=1 instance.
module tb_spi_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data, f_tx_data;
  logic       tx_valid, tx_last, abort;
  logic       f_tx_valid, f_tx_last, f_abort;
  logic       tx_ready, sclk, mosi, csn, busy, done;
  logic       f_tx_ready, f_sclk, f_mosi, f_csn, f_busy, f_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] fexp_q[$];

  always #5 clk = ~clk;

  spi_encoder u_dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .abort(abort), .sclk(sclk), .mosi(mosi), .csn(csn),
    .busy(busy), .done(done)
  );

  spi_encoder #(.HALF_PERIOD(1), .CS_GAP(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .tx_data(f_tx_data), .tx_valid(f_tx_valid), .tx_last(f_tx_last),
    .tx_ready(f_tx_ready), .abort(f_abort), .sclk(f_sclk), .mosi(f_mosi), .csn(f_csn),
    .busy(f_busy), .done(f_done)
  );

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, want, want, $time);
    end
  endtask

  // Decoder/monitor for the default instance
  int         cyc = 0;
  bit         p_sclk = 1'b0, p_csn = 1'b1;
  logic [7:0] sh = 8'd0;
  int         nbits = 0, frame_rises = 0, low_len = 0, last_low_len = 0, last_rises = 0;
  int         csn_falls = 0, done_cnt = 0, done_at_rise = 0;
  int         fall_cyc = 0, first_rise_delay = 0, last_rise_cyc = 0, sp_min = 0, sp_max = 0;
  logic [7:0] rise_bits = 8'd0;

  always @(negedge clk) begin
    cyc++;
    if (!csn) begin
      if (p_csn) begin
        csn_falls++; fall_cyc = cyc; low_len = 0; frame_rises = 0; nbits = 0;
        sp_min = 1000; sp_max = 0;
      end
      low_len++;
      if (sclk && !p_sclk) begin
        if (frame_rises == 0) first_rise_delay = cyc - fall_cyc;
        else if (nbits == 0) begin
          if (cyc - last_rise_cyc < sp_min) sp_min = cyc - last_rise_cyc;
          if (cyc - last_rise_cyc > sp_max) sp_max = cyc - last_rise_cyc;
        end
        last_rise_cyc = cyc;
        frame_rises++;
        sh = {sh[6:0], mosi};
        rise_bits = {rise_bits[6:0], mosi};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (exp_q.size() == 0) check("sb_unexpected_byte", int'(sh), -1);
          else check("sb_byte", int'(sh), int'(exp_q.pop_front()));
        end
      end
    end else begin
      if (!p_csn) begin
        last_low_len = low_len; last_rises = frame_rises;
        if (done) done_at_rise++;
      end
      nbits = 0;
    end
    if (done) done_cnt++;
    p_sclk = sclk; p_csn = csn;
  end

  // Decoder/monitor for the fast instance
  bit         fp_sclk = 1'b0, fp_csn = 1'b1;
  logic [7:0] f_sh = 8'd0;
  int         f_nbits = 0, f_low = 0, f_high = 0, f_last_low = 0, f_last_high = 0, f_done_cnt = 0;

  always @(negedge clk) begin
    if (!f_csn) begin
      if (fp_csn) begin f_last_high = f_high; f_low = 0; f_nbits = 0; end
      f_low++;
      if (f_sclk && !fp_sclk) begin
        f_sh = {f_sh[6:0], f_mosi};
        f_nbits++;
        if (f_nbits == 8) begin
          f_nbits = 0;
          if (fexp_q.size() == 0) check("fast_sb_unexpected_byte", int'(f_sh), -1);
          else check("fast_sb_byte", int'(f_sh), int'(fexp_q.pop_front()));
        end
      end
    end else begin
      if (!fp_csn) begin f_last_low = f_low; f_high = 0; end
      f_high++;
      f_nbits = 0;
    end
    if (f_done) f_done_cnt++;
    fp_sclk = f_sclk; fp_csn = f_csn;
  end

  task automatic send(input bit sel, input logic [7:0] d, input bit l, input bit hold, input bit exp_b);
    int n;
    n = 0;
    if (sel) begin
      f_tx_data = d; f_tx_last = l; f_tx_valid = 1'b1;
      if (exp_b) fexp_q.push_back(d);
    end else begin
      tx_data = d; tx_last = l; tx_valid = 1'b1;
      if (exp_b) exp_q.push_back(d);
    end
    while (!(sel ? f_tx_ready : tx_ready) && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 2000) check("send_timeout", n, 0);
    @(posedge clk); #1;
    if (!hold) begin
      if (sel) f_tx_valid = 1'b0; else tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    @(negedge clk);
    while ((sel ? f_busy : busy) && n < 1000) begin
      @(negedge clk); n++;
    end
    if (n >= 1000) check("idle_timeout", n, 0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_rises(input int r);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (frame_rises < r && n < 1000) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 1000) check("rise_timeout", n, 0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!tx_ready && n < 1000) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 1000) check("ready_timeout", n, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0, bad;
    rst_n = 1'b0;
    tx_data = 8'd0; tx_valid = 1'b0; tx_last = 1'b0; abort = 1'b0;
    f_tx_data = 8'd0; f_tx_valid = 1'b0; f_tx_last = 1'b0; f_abort = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;

    check("rst_sclk", int'(sclk), 0);
    check("rst_mosi", int'(mosi), 0);
    check("rst_csn", int'(csn), 1);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tx_ready", int'(tx_ready), 1);

    // Single-byte frame 0xA5
    d0 = done_cnt; f0 = done_at_rise;
    send(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1);
    wait_idle(1'b0);
    check("a5_mosi_at_rises", int'(rise_bits), 8'hA5);
    check("a5_csn_low_len", last_low_len, 34);
    check("a5_rises", last_rises, 8);
    check("a5_first_rise_delay", first_rise_delay, 2);
    check("a5_done_count", done_cnt - d0, 1);
    check("a5_done_at_csn_rise", done_at_rise - f0, 1);

    // Three-byte frame with tx_valid held high
    d0 = done_cnt; f0 = csn_falls;
    send(1'b0, 8'h3C, 1'b0, 1'b1, 1'b1);
    send(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);
    send(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_idle(1'b0);
    check("b2b_csn_windows", csn_falls - f0, 1);
    check("b2b_rises", last_rises, 24);
    check("b2b_spacing_min", sp_min, 5);
    check("b2b_spacing_max", sp_max, 5);
    check("b2b_done_count", done_cnt - d0, 1);

    // Stall in NEXT
    d0 = done_cnt; f0 = csn_falls;
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    wait_ready();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (csn !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1) bad++;
      @(negedge clk); #1;
    end
    check("next_stall_bad_cycles", bad, 0);
    send(1'b0, 8'h22, 1'b1, 1'b0, 1'b1);
    wait_idle(1'b0);
    check("stall_csn_windows", csn_falls - f0, 1);
    check("stall_done_count", done_cnt - d0, 1);

    // abort collides with an offered byte in NEXT
    d0 = done_cnt;
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_ready();
    tx_data = 8'h66; tx_last = 1'b1; tx_valid = 1'b1; abort = 1'b1;
    #1;
    check("abort_next_tx_ready", int'(tx_ready), 0);
    @(posedge clk); #1;
    tx_valid = 1'b0; abort = 1'b0;
    check("abort_next_csn", int'(csn), 1);
    wait_idle(1'b0);
    check("abort_next_no_done", done_cnt - d0, 0);

    // abort after the 3rd rise of 0xF0
    d0 = done_cnt;
    send(1'b0, 8'hF0, 1'b0, 1'b0, 1'b0);
    wait_rises(3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_csn", int'(csn), 1);
    check("abort_sclk", int'(sclk), 0);
    check("abort_mosi", int'(mosi), 0);
    wait_idle(1'b0);
    check("abort_no_done", done_cnt - d0, 0);
    send(1'b0, 8'h81, 1'b1, 1'b0, 1'b1);
    wait_idle(1'b0);

    // Asynchronous reset mid-byte
    send(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    wait_rises(5);
    rst_n = 1'b0;
    #1;
    check("arst_sclk", int'(sclk), 0);
    check("arst_csn", int'(csn), 1);
    check("arst_mosi", int'(mosi), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_tx_ready", int'(tx_ready), 1);

    // HALF_PERIOD=1, CS_GAP=1 back-to-back single-byte frames
    d0 = f_done_cnt;
    send(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
    send(1'b1, 8'h80, 1'b1, 1'b0, 1'b1);
    wait_idle(1'b1);
    check("fast_csn_high_gap", f_last_high, 1);
    check("fast_csn_low_len", f_last_low, 17);
    check("fast_done_count", f_done_cnt - d0, 2);

    check("sb_leftover", exp_q.size(), 0);
    check("fast_sb_leftover", fexp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
